// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style bus responder: state encoding,
// instruction masks, address constants and AC stepping helpers.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISP,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } op_e;

  localparam logic [7:0] MASK_DDRAM = 8'h80;
  localparam logic [7:0] MASK_CGRAM = 8'h40;
  localparam logic [7:0] MASK_FUNC  = 8'h20;
  localparam logic [7:0] MASK_SHIFT = 8'h10;
  localparam logic [7:0] MASK_DISP  = 8'h08;
  localparam logic [7:0] MASK_ENTRY = 8'h04;
  localparam logic [7:0] MASK_HOME  = 8'h02;
  localparam logic [7:0] MASK_CLEAR = 8'h01;

  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE0_END  = 7'h27;
  localparam logic [6:0] LINE1_END  = 7'h67;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Instruction class is chosen by the highest set bit.
  function automatic op_e decode_op(input logic [7:0] d);
    if ((d & MASK_DDRAM) != 8'h00) return OP_DDRAM;
    if ((d & MASK_CGRAM) != 8'h00) return OP_CGRAM;
    if ((d & MASK_FUNC)  != 8'h00) return OP_FUNC;
    if ((d & MASK_SHIFT) != 8'h00) return OP_SHIFT;
    if ((d & MASK_DISP)  != 8'h00) return OP_DISP;
    if ((d & MASK_ENTRY) != 8'h00) return OP_ENTRY;
    if ((d & MASK_HOME)  != 8'h00) return OP_HOME;
    if ((d & MASK_CLEAR) != 8'h00) return OP_CLEAR;
    return OP_NONE;
  endfunction

  // Step AC across the two 40-address lines; out-of-line values snap to
  // the nearest legal neighbour in the stepping direction.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac[6]) return (ac >= LINE1_END) ? 7'h00 : ac + 7'd1;
      return (ac >= LINE0_END) ? LINE1_BASE : ac + 7'd1;
    end
    if (ac == 7'h00) return LINE1_END;
    if (ac == LINE1_BASE) return LINE0_END;
    if (!ac[6] && (ac > LINE0_END)) return LINE0_END;
    if (ac[6] && (ac > LINE1_END)) return LINE1_END;
    return ac - 7'd1;
  endfunction

  function automatic logic [4:0] cell_of(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32 x 8 display cell store: one synchronous write port, a registered host
// read port with write-through, and a combinational bus read port.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] haddr_i,
  output logic [7:0] hdata_o,
  input  logic [4:0] baddr_i,
  output logic [7:0] bdata_o
);

  logic [7:0] mem_q [32];
  logic [7:0] hdata_q;

  // Cell array: reset fills with spaces, otherwise single-port write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= SPACE_CHAR;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Host read: one cycle latency, same-cycle write forwarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdata_q <= SPACE_CHAR;
    end else if (we_i && (waddr_i == haddr_i)) begin
      hdata_q <= wdata_i;
    end else begin
      hdata_q <= mem_q[haddr_i];
    end
  end

  assign hdata_o = hdata_q;
  assign bdata_o = mem_q[baddr_i];

endmodule

// File: rtl/lcd_bus_responder.sv
// Emulates the bus side of a 2-line HD44780 character LCD.
// state | meaning
// IDLE  | ready; decode a transaction on each E falling edge
// EXEC  | busy for BUSY_CYCLES after an accepted write
// CLEAR | writing spaces into cells 0..31, one per cycle
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int BUSY_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       display_on,
  output logic       wr_strobe,
  output logic       protocol_err
);

  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    clr_q, clr_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          don_q, don_d;
  logic          perr_q, perr_d;
  logic          e_q, rs_q, rw_q;
  logic [7:0]    data_q;

  logic          fall, go_exec, we, ac_on_map;
  logic [4:0]    waddr;
  logic [7:0]    wdata, bus_cell;

  assign fall      = e_q & ~LCD_E & ~rst;
  assign ac_on_map = (int'({26'd0, ac_q[5:0]}) < COLS);

  // Bus sampling and control/state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= 8'h00;
      state_q <= IDLE;
      cnt_q   <= '0;
      clr_q   <= 5'd0;
      ac_q    <= 7'h00;
      id_q    <= 1'b1;
      don_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      e_q     <= LCD_E;
      rs_q    <= LCD_RS;
      rw_q    <= LCD_RW;
      data_q  <= LCD_DATA;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      don_q   <= don_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state, instruction decode and cell write control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    ac_d    = ac_q;
    id_d    = id_q;
    don_d   = don_q;
    perr_d  = perr_q;
    go_exec = 1'b0;
    we      = 1'b0;
    waddr   = cell_of(ac_q);
    wdata   = data_q;
    case (state_q)
      IDLE: begin
        if (fall && !rw_q && rs_q) begin
          we      = ac_on_map;
          ac_d    = ac_step(ac_q, id_q);
          go_exec = 1'b1;
        end else if (fall && !rw_q) begin
          case (decode_op(data_q))
            OP_DDRAM: begin ac_d = data_q[6:0]; go_exec = 1'b1; end
            OP_CGRAM: perr_d = 1'b1;
            OP_FUNC:  go_exec = 1'b1;
            OP_SHIFT: begin
              if (!data_q[3]) ac_d = ac_step(ac_q, data_q[2]);
              go_exec = 1'b1;
            end
            OP_DISP:  begin don_d = data_q[2]; go_exec = 1'b1; end
            OP_ENTRY: begin id_d = data_q[1]; go_exec = 1'b1; end
            OP_HOME:  begin ac_d = 7'h00; go_exec = 1'b1; end
            OP_CLEAR: begin state_d = CLEAR; clr_d = 5'd0; end
            default:  ;
          endcase
        end else if (fall && rs_q) begin
          ac_d = ac_step(ac_q, id_q);
        end
      end
      EXEC: begin
        if (fall && !rw_q) perr_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      CLEAR: begin
        if (fall && !rw_q) perr_d = 1'b1;
        we    = 1'b1;
        waddr = clr_q;
        wdata = SPACE_CHAR;
        if (clr_q == 5'd31) begin
          ac_d    = 7'h00;
          id_d    = 1'b1;
          go_exec = 1'b1;
        end else begin
          clr_d = clr_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_exec) begin
      state_d = EXEC;
      cnt_d   = CNT_LOAD;
    end
  end

  lcd_ddram u_ddram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .haddr_i (rd_addr),
    .hdata_o (rd_data),
    .baddr_i (cell_of(ac_q)),
    .bdata_o (bus_cell)
  );

  assign busy         = (state_q != IDLE);
  assign display_on   = don_q;
  assign protocol_err = perr_q;
  assign wr_strobe    = we & ~rst;
  assign lcd_doe      = LCD_E & LCD_RW & ~rst;
  assign lcd_dout     = !lcd_doe ? 8'h00 :
                        !LCD_RS  ? {busy, ac_q} :
                        ac_on_map ? bus_cell : SPACE_CHAR;

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter COLS, default 16, meaning visible characters per line (2 lines fixed).
REQ-002 SHALL have parameter BUSY_CYCLES, default 40, meaning clk cycles busy after a non-clear write.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 LCD_E  input  1  bus enable from LCD driver.
REQ-006 LCD_RS  input  1  0 = instruction/status, 1 = data.
REQ-007 LCD_RW  input  1  0 = write, 1 = read.
REQ-008 LCD_DATA  input  8  write data from driver.
REQ-009 lcd_dout  output  8  read data returned to driver.
REQ-010 lcd_doe  output  1  high while lcd_dout is driven.
REQ-011 rd_addr  input  5  host display-cell index: bit4 = line, bits3:0 = column.
REQ-012 rd_data  output  8  character at rd_addr, one cycle latency.
REQ-013 busy  output  1  emulated HD44780 busy flag.
REQ-014 display_on  output  1  D bit from last display-control command.
REQ-015 wr_strobe  output  1  one-cycle pulse per DDRAM cell written (data write or clear step).
REQ-016 protocol_err  output  1  sticky: access while busy, or CGRAM access.

Function
REQ-017 SHALL register LCD_E, LCD_RS, LCD_RW and LCD_DATA each cycle; a bus transaction SHALL occur on a detected E falling edge (registered E = 1, current E = 0) using the values registered in the last E-high cycle.
REQ-018 State machine SHALL have states IDLE, EXEC, CLEAR; busy = 1 in EXEC and CLEAR.
REQ-019 Write with busy = 1 (RS=0 or RS=1) SHALL be ignored and set protocol_err; status read SHALL always be honoured.
REQ-020 Instruction decode by highest set bit: 0x01 clear; 0x02-0x03 home (AC = 0); 0x04-0x07 entry mode (store I/D = bit1, shift bit ignored); 0x08-0x0F display control (display_on = bit2); 0x10-0x1F cursor shift (bit3 = 0: AC +1 if bit2 else -1; bit3 = 1: no-op); 0x20-0x3F function set (no effect); 0x40-0x7F CGRAM address (ignored, set protocol_err); 0x80-0xFF AC = data[6:0].
REQ-021 Every accepted instruction except clear SHALL go IDLE -> EXEC for exactly BUSY_CYCLES cycles, then return to IDLE.
REQ-022 Clear SHALL go IDLE -> CLEAR and write 0x20 to cells 0..31, one per cycle with wr_strobe each, then set AC = 0 and I/D = 1, then enter EXEC for BUSY_CYCLES.
REQ-023 Data write SHALL store data at AC if AC[5:0] < COLS (line = AC[6]); otherwise no store, no wr_strobe; AC then steps per I/D; EXEC follows.
REQ-024 AC stepping SHALL wrap 0x27 -> 0x40, 0x67 -> 0x00 (increment) and 0x40 -> 0x27, 0x00 -> 0x67 (decrement); AC values 0x28-0x3F and 0x68-0x7F set by 0x80 commands SHALL be held, with the next step from them going to 0x40 (increment from 0x28-0x3F) or 0x00 (increment from 0x68-0x7F).
REQ-025 Status read (RS=0, RW=1): lcd_dout = {busy, AC} and lcd_doe = 1 in every cycle with LCD_E = 1 and LCD_RW = 1; no state change on the falling edge.
REQ-026 Data read (RS=1, RW=1), when not busy: lcd_dout = cell at AC (0x20 if off-map) while E high; on the falling edge AC steps per I/D, with no EXEC.
REQ-027 lcd_doe SHALL be 0 whenever LCD_RW = 0 or LCD_E = 0.
REQ-028 rd_data SHALL reflect rd_addr sampled in the previous cycle, including writes committed in that cycle.

Reset
REQ-029 rst SHALL force IDLE, all 32 cells = 0x20, AC = 0, I/D = 1, busy = 0, display_on = 0, wr_strobe = 0, protocol_err = 0, lcd_doe = 0, lcd_dout = 0x00, rd_data = 0x20.
REQ-030 rst asserted mid-CLEAR or mid-EXEC SHALL abort the operation in that cycle; no transaction is decoded in the reset cycle.

Structure
REQ-031 Shared package lcd_pkg SHALL hold opcode masks, LINE1_BASE = 0x40, SPACE_CHAR = 0x20 and the state encoding.
REQ-032 Display storage SHALL be sub-module lcd_ddram: 32 x 8, one synchronous write port, two read ports (host, bus).

Verification
REQ-033 Reset, then write 0x80 followed by data 0x32 -> cell 0 = 0x32 after BUSY_CYCLES; rd_addr = 0 gives rd_data = 0x32; AC = 0x01.
REQ-034 0xC0 followed by 17 data writes -> cells 16-31 written, 17th write has no wr_strobe, AC = 0x51.
REQ-035 0x01 -> busy for 32 + BUSY_CYCLES cycles, 32 wr_strobe pulses, all cells = 0x20; status read afterwards returns 0x00.
REQ-036 Data write issued 5 cycles after 0x0C -> ignored, protocol_err = 1, display_on = 1.
REQ-037 AC = 0x27 with I/D = 1 and a data write -> AC = 0x40; entry mode 0x04 at AC = 0x00 and a data write -> AC = 0x67.
REQ-038 rst during CLEAR at cell 10 -> next cycle IDLE, busy = 0, all cells = 0x20.
